// File: rtl/pll_dda_ctrl.sv
// PLL dynamic-delay-adjust controller: encodes a signed delay request onto the DDA pins and supervises relock.
// Build macro PLL_DDA_RAMP_EN: walk the applied code one step per relock toward the target.
module pll_dda_ctrl #(
  parameter int unsigned UNLOCK_WAIT  = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned SETTLE_CYC   = 8
) (
  input  logic       CLKI,
  input  logic       RSTN,
  input  logic       REQ,
  input  logic [4:0] TGT,
  output logic       ACK,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  output logic       BUSY,
  output logic [4:0] CUR,
  output logic       LOCKED,
  input  logic       LOCK,
  output logic       DDAMODE,
  output logic       DDAIZR,
  output logic       DDAILAG,
  output logic [2:0] DDAIDEL
);
  localparam int unsigned   CW       = 16;
  localparam int unsigned   SW       = 8;
  localparam logic [CW-1:0] UW_MAX   = CW'(UNLOCK_WAIT);
  localparam logic [CW-1:0] LT_TRIP  = CW'(LOCK_TIMEOUT - 32'd2);
  localparam logic [SW-1:0] SC_LAST  = SW'(SETTLE_CYC - 32'd1);
  localparam logic [1:0]    EC_NONE  = 2'b00;
  localparam logic [1:0]    EC_RANGE = 2'b01;
  localparam logic [1:0]    EC_TMO   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_WAIT_UNLOCK, S_WAIT_LOCK, S_SETTLE, S_RESP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_scnt;
  logic [4:0]    r_tgt, r_cur;
  logic [1:0]    r_pend, r_err_code;
  logic          r_mode, r_izr, r_ilag, r_ack, r_err, r_busy;
  logic [2:0]    r_idel;

  logic          w_tgt_oor, w_more, w_accept, w_cnt_clr, w_scnt_clr, w_code_ld;
  logic [1:0]    w_code_val;
  logic [4:0]    w_step, w_mag;

  assign w_tgt_oor = ($signed(TGT) > 5'sd8) || ($signed(TGT) < -5'sd8);

`ifdef PLL_DDA_RAMP_EN
  // First step after reset only switches to dynamic mode at the present code.
  always_comb begin
    w_step = r_cur;
    if (r_mode) begin
      if ($signed(r_tgt) > $signed(r_cur))      w_step = r_cur + 5'd1;
      else if ($signed(r_tgt) < $signed(r_cur)) w_step = r_cur - 5'd1;
    end
  end
  assign w_more = (r_cur != r_tgt);
`else
  assign w_step = r_tgt;
  assign w_more = 1'b0;
`endif

  assign w_mag = w_step[4] ? (~w_step + 5'd1) : w_step;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_scnt_clr  = 1'b0;
    w_code_ld   = 1'b0;
    w_code_val  = EC_NONE;
    unique case (r_state)
      S_IDLE: begin
        // Ignore REQ during the ACK cycle so a still-held request is not re-accepted.
        if (REQ && !r_ack) begin
          w_accept  = 1'b1;
          w_code_ld = 1'b1;
          if (w_tgt_oor) begin
            w_code_val  = EC_RANGE;
            w_state_nxt = S_RESP;
          end else if ((TGT == r_cur) && r_mode) begin
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_APPLY;
          end
        end
      end
      S_APPLY: w_state_nxt = S_WAIT_UNLOCK;
      S_WAIT_UNLOCK: begin
        if (!r_sync2 || (r_cnt >= UW_MAX)) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        // Trip two early: one cycle for RESP, one for the registered ACK.
        if (r_sync2) begin
          w_scnt_clr  = 1'b1;
          w_state_nxt = S_SETTLE;
        end else if (r_cnt >= LT_TRIP) begin
          w_code_ld   = 1'b1;
          w_code_val  = EC_TMO;
          w_state_nxt = S_RESP;
        end
      end
      S_SETTLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (r_scnt >= SC_LAST) begin
          if (w_more) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_APPLY;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_scnt  <= '0;
      r_tgt   <= '0;
      r_pend  <= EC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= LOCK;
      r_sync2 <= r_sync1;
      if (w_cnt_clr)                r_cnt <= '0;
      else if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + CW'(1);
      if (w_scnt_clr)                                                   r_scnt <= '0;
      else if ((r_state == S_SETTLE) && r_sync2 && (r_scnt != {SW{1'b1}})) r_scnt <= r_scnt + SW'(1);
      if (w_accept)  r_tgt  <= TGT;
      if (w_code_ld) r_pend <= w_code_val;
    end
  end

  // Handshake outputs; ACK and the error fields follow RESP by one cycle.
  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= EC_NONE;
      r_busy     <= 1'b0;
    end else begin
      r_ack      <= (r_state == S_RESP);
      r_err      <= (r_state == S_RESP) && (r_pend != EC_NONE);
      r_err_code <= (r_state == S_RESP) ? r_pend : EC_NONE;
      r_busy     <= (w_state_nxt != S_IDLE) || (r_state == S_RESP);
    end
  end

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      r_cur  <= '0;
      r_mode <= 1'b0;
      r_izr  <= 1'b0;
      r_ilag <= 1'b0;
      r_idel <= '0;
    end else if (r_state == S_APPLY) begin
      r_cur  <= w_step;
      r_mode <= 1'b1;
      r_izr  <= (w_step == 5'd0);
      r_ilag <= w_step[4];
      r_idel <= (w_step == 5'd0) ? 3'd0 : 3'(w_mag - 5'd1);
    end
  end

  assign ACK      = r_ack;
  assign ERR      = r_err;
  assign ERR_CODE = r_err_code;
  assign BUSY     = r_busy;
  assign CUR      = r_cur;
  assign LOCKED   = r_sync2;
  assign DDAMODE  = r_mode;
  assign DDAIZR   = r_izr;
  assign DDAILAG  = r_ilag;
  assign DDAIDEL  = r_idel;
endmodule

// File: tb/tb_pll_dda_ctrl.sv
// Directed bench for pll_dda_ctrl: scoreboard of expected responses checked on each ACK.
module tb_pll_dda_ctrl;
  localparam int UW = 16;
  localparam int LT = 4096;
  localparam int SC = 8;
  localparam int STEP_LAT = UW + SC + 2;
`ifdef PLL_DDA_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       CLKI = 1'b0;
  logic       RSTN, REQ, LOCK;
  logic [4:0] TGT;
  logic       ACK, ERR, BUSY, LOCKED, DDAMODE, DDAIZR, DDAILAG;
  logic [1:0] ERR_CODE;
  logic [4:0] CUR;
  logic [2:0] DDAIDEL;

  pll_dda_ctrl #(.UNLOCK_WAIT(UW), .LOCK_TIMEOUT(LT), .SETTLE_CYC(SC)) dut (
    .CLKI(CLKI), .RSTN(RSTN), .REQ(REQ), .TGT(TGT), .ACK(ACK), .ERR(ERR),
    .ERR_CODE(ERR_CODE), .BUSY(BUSY), .CUR(CUR), .LOCKED(LOCKED), .LOCK(LOCK),
    .DDAMODE(DDAMODE), .DDAIZR(DDAIZR), .DDAILAG(DDAILAG), .DDAIDEL(DDAIDEL)
  );

  always #5 CLKI = ~CLKI;

  int cyc = 0;
  always @(posedge CLKI) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [1:0] code;
    logic [4:0] cur;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  ramp_seq[$];
  int          n_chk, n_fail, t_acc, m_cur;
  bit          m_mode;
  logic [5:0]  pins;
  logic [16:0] all_out;

  assign pins    = {DDAMODE, DDAIZR, DDAILAG, DDAIDEL};
  assign all_out = {ACK, ERR, ERR_CODE, BUSY, CUR, LOCKED, DDAMODE, DDAIZR, DDAILAG, DDAIDEL};

  function automatic logic [5:0] pins_of(input int v);
    if (v == 0) return 6'b110000;
    if (v > 0)  return {3'b100, 3'(v - 1)};
    return {3'b101, 3'(-v - 1)};
  endfunction

  function automatic int n_steps(input int from, input int to, input bit mode);
    int d;
    d = (to > from) ? to - from : from - to;
    if (!RAMP) return 1;
    return d + (mode ? 0 : 1);
  endfunction

  function automatic int first_step(input int from, input int to, input bit mode);
    if (!RAMP) return to;
    if (!mode) return from;
    return (to > from) ? from + 1 : from - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic [1:0] code, input int cur, input int lat);
    exp_t e;
    e.err  = err;
    e.code = code;
    e.cur  = 5'(cur);
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic send(input int t);
    @(negedge CLKI);
    REQ = 1'b1;
    TGT = 5'(t);
    @(negedge CLKI);
    t_acc = cyc;
    check("busy_on_accept", 32'(BUSY), 32'd1);
  endtask

  task automatic wait_and_score(input string tag);
    exp_t e;
    bit   seen;
    int   lat;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge CLKI);
      if (ACK === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - t_acc;
      end
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        check({tag, "_err"},     32'(ERR),      32'(e.err));
        check({tag, "_errcode"}, 32'(ERR_CODE), 32'(e.code));
        check({tag, "_cur"},     32'(CUR),      32'(e.cur));
        check({tag, "_latency"}, 32'(lat),      32'(e.lat));
      end
    end
    REQ = 1'b0;
    @(negedge CLKI);
    check({tag, "_ack_busy_fall"}, 32'({ACK, BUSY, ERR, ERR_CODE}), 32'd0);
  endtask

  task automatic run_inrange(input string tag, input int t);
    push_exp(1'b0, 2'b00, t, STEP_LAT * n_steps(m_cur, t, m_mode) + 1);
    send(t);
    wait_and_score(tag);
    m_cur  = t;
    m_mode = 1'b1;
    check({tag, "_pins"}, 32'(pins), 32'(pins_of(t)));
  endtask

  task automatic run_range(input string tag, input int t);
    push_exp(1'b1, 2'b01, m_cur, 1);
    send(t);
    wait_and_score(tag);
    check({tag, "_pins_kept"}, 32'(pins), 32'(pins_of(m_cur)));
  endtask

  initial begin
    bit ack_during_reset;
    RSTN = 1'b0; REQ = 1'b0; TGT = '0; LOCK = 1'b1;
    n_chk = 0; n_fail = 0; m_cur = 0; m_mode = 1'b0; t_acc = 0;
    repeat (3) @(negedge CLKI);
    check("reset_outputs", 32'(all_out), 32'd0);
    RSTN = 1'b1;
    repeat (3) @(negedge CLKI);
    check("locked_after_sync", 32'(LOCKED), 32'd1);
    check("static_mode_idle", 32'(pins), 32'd0);

    run_inrange("pos3", 3);
    run_inrange("neg8", -8);
    run_inrange("zero", 0);

    // Same code again while dynamic: answered without touching the pins.
    push_exp(1'b0, 2'b00, m_cur, 1);
    send(m_cur);
    wait_and_score("noop");

    run_range("over9", 9);
    run_range("under9", -9);

    // Two-cycle LOCK glitch landing on the last settle cycle.
    push_exp(1'b0, 2'b00, 5, STEP_LAT * n_steps(m_cur, 5, m_mode) + 1 + 2 + SC);
    send(5);
    repeat (23) @(negedge CLKI);
    LOCK = 1'b0;
    repeat (2) @(negedge CLKI);
    LOCK = 1'b1;
    wait_and_score("glitch");
    m_cur = 5; m_mode = 1'b1;

    // LOCK lost three cycles after APPLY and never recovers.
    push_exp(1'b1, 2'b10, first_step(m_cur, -3, m_mode), 7 + LT);
    send(-3);
    repeat (4) @(negedge CLKI);
    LOCK = 1'b0;
    @(negedge CLKI);
    check("locked_lag_1", 32'(LOCKED), 32'd1);
    @(negedge CLKI);
    check("locked_lag_2", 32'(LOCKED), 32'd0);
    wait_and_score("timeout");
    m_cur = first_step(m_cur, -3, m_mode); m_mode = 1'b1;
    check("timeout_pins", 32'(pins), 32'(pins_of(m_cur)));
    LOCK = 1'b1;
    repeat (3) @(negedge CLKI);

    // Asynchronous reset in the middle of a sequence.
    send(1);
    repeat (10) @(negedge CLKI);
    RSTN = 1'b0;
    #1;
    check("midop_reset_outputs", 32'(all_out), 32'd0);
    REQ = 1'b0;
    repeat (3) @(negedge CLKI);
    RSTN = 1'b1;
    m_cur = 0; m_mode = 1'b0;
    ack_during_reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLKI);
      if (ACK !== 1'b0) ack_during_reset = 1'b1;
    end
    check("midop_no_ack", 32'(ack_during_reset), 32'd0);
    check("midop_static_mode", 32'(pins), 32'd0);

    // Zero from static mode is a real apply, not a no-op.
    run_inrange("zero_first", 0);

`ifdef PLL_DDA_RAMP_EN
    run_inrange("ramp_up", 2);
    ramp_seq.delete();
    fork
      begin
        logic [4:0] last;
        last = CUR;
        while (ACK !== 1'b1) begin
          @(negedge CLKI);
          if (CUR !== last) begin
            ramp_seq.push_back(CUR);
            last = CUR;
          end
        end
      end
    join_none
    run_inrange("ramp_cross", -2);
    check("ramp_len", 32'(ramp_seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < ramp_seq.size(); i++)
      check("ramp_step", 32'(ramp_seq[i]), 32'(5'(1 - i)));
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
